// File: rtl/counter_checker.sv
// counter_checker: passive reference-model checker for a 4-bit loadable
// up/down counter. Watches the counter's observed stimulus and output,
// predicts the next value cycle by cycle, and reports, counts and captures
// any disagreement. Drives nothing back onto the observed interface.
//
//   state  | meaning
//   SYNC   | model not yet aligned; waiting for an observed reset or load
//   CHECK  | model aligned; compares run whenever vld_q is set
//   HALT   | stopped after the first mismatch (STOP_ON_ERROR only)
module counter_checker #(
  parameter int WIDTH         = 4,
  parameter int CHK_CNT_W     = 16,
  parameter int ERR_CNT_W     = 8,
  parameter int STOP_ON_ERROR = 0
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 mon_rst_n,
  input  logic                 mon_enable,
  input  logic                 mon_load,
  input  logic                 mon_up_down_n,
  input  logic [WIDTH-1:0]     mon_data_input,
  input  logic [WIDTH-1:0]     mon_data_output,
  input  logic                 chk_en,
  output logic                 synced,
  output logic                 mismatch,
  output logic                 err_sticky,
  output logic [CHK_CNT_W-1:0] chk_count,
  output logic [ERR_CNT_W-1:0] err_count,
  output logic [WIDTH-1:0]     first_exp,
  output logic [WIDTH-1:0]     first_act
);

  typedef enum logic [1:0] {
    ST_SYNC  = 2'd0,
    ST_CHECK = 2'd1,
    ST_HALT  = 2'd2
  } state_t;

  state_t                state_q, state_d;
  logic [WIDTH-1:0]      exp_q, exp_d;
  logic                  vld_q, vld_d;
  logic                  mismatch_q, mismatch_d;
  logic                  err_sticky_q, err_sticky_d;
  logic [CHK_CNT_W-1:0]  chk_count_q, chk_count_d;
  logic [ERR_CNT_W-1:0]  err_count_q, err_count_d;
  logic [WIDTH-1:0]      first_exp_q, first_exp_d;
  logic [WIDTH-1:0]      first_act_q, first_act_d;

  logic [WIDTH-1:0]      model_d;
  logic                  compare;
  logic                  fail;

  // Reference counter next value: observed reset beats load beats count.
  always_comb begin
    model_d = exp_q;
    if (!mon_rst_n) begin
      model_d = '0;
    end else if (mon_load) begin
      model_d = mon_data_input;
    end else if (mon_enable) begin
      model_d = mon_up_down_n ? (exp_q + 1'b1) : (exp_q - 1'b1);
    end
  end

  // The output seen now reflects stimulus from the previous edge, which is
  // exactly what exp_q holds, so compare directly against exp_q.
  assign compare = (state_q == ST_CHECK) && vld_q;
  assign fail    = compare && (mon_data_output != exp_q);

  // Next-state, model tracking, compare bookkeeping and first-fail capture.
  always_comb begin
    state_d      = state_q;
    exp_d        = exp_q;
    chk_count_d  = chk_count_q;
    err_count_d  = err_count_q;
    err_sticky_d = err_sticky_q;
    first_exp_d  = first_exp_q;
    first_act_d  = first_act_q;
    mismatch_d   = fail;

    case (state_q)
      ST_SYNC: begin
        // Only a reset or a load gives a known counter value to lock onto.
        if (!mon_rst_n || mon_load) begin
          exp_d   = model_d;
          state_d = ST_CHECK;
        end
      end
      ST_CHECK: begin
        exp_d = model_d;
        if (fail && (STOP_ON_ERROR != 0)) begin
          state_d = ST_HALT;
        end
      end
      ST_HALT: begin
        // Everything frozen until checker reset.
      end
      default: begin
        state_d = ST_SYNC;
      end
    endcase

    if (compare && (chk_count_q != '1)) begin
      chk_count_d = chk_count_q + 1'b1;
    end

    if (fail) begin
      if (err_count_q != '1) begin
        err_count_d = err_count_q + 1'b1;
      end
      err_sticky_d = 1'b1;
      if (!err_sticky_q) begin
        first_exp_d = exp_q;
        first_act_d = mon_data_output;
      end
    end

    vld_d = (state_d == ST_CHECK) && chk_en;
  end

  // State and status registers with asynchronous checker reset.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= ST_SYNC;
      exp_q        <= '0;
      vld_q        <= 1'b0;
      mismatch_q   <= 1'b0;
      err_sticky_q <= 1'b0;
      chk_count_q  <= '0;
      err_count_q  <= '0;
      first_exp_q  <= '0;
      first_act_q  <= '0;
    end else begin
      state_q      <= state_d;
      exp_q        <= exp_d;
      vld_q        <= vld_d;
      mismatch_q   <= mismatch_d;
      err_sticky_q <= err_sticky_d;
      chk_count_q  <= chk_count_d;
      err_count_q  <= err_count_d;
      first_exp_q  <= first_exp_d;
      first_act_q  <= first_act_d;
    end
  end

  assign synced     = (state_q != ST_SYNC);
  assign mismatch   = mismatch_q;
  assign err_sticky = err_sticky_q;
  assign chk_count  = chk_count_q;
  assign err_count  = err_count_q;
  assign first_exp  = first_exp_q;
  assign first_act  = first_act_q;

endmodule

// File: doc/counter_checker.md
Name: counter_checker

Overview:
- Passive monitor-side block that attaches to the monitor view of the up/down counter interface.
- Runs a cycle-accurate reference model of the 4-bit loadable up/down counter and compares every DUT output against it.
- Reports mismatches, counts checks and errors, and captures the first failing values.
- Consumes the DUT's observed inputs and output and drives nothing back onto the interface. It is the checking end of the driver-to-DUT path.

Parameters:
- WIDTH, 4, counter data width. Applies to mon_data_input, mon_data_output, first_exp and first_act.
- CHK_CNT_W, 16, width of the check counter.
- ERR_CNT_W, 8, width of the error counter.
- STOP_ON_ERROR, 0. When 1, the block enters HALT on the first mismatch.

Ports:
- clk  input  1  system clock, rising-edge.
- rst  input  1  checker reset, asynchronous, active-high.
- mon_rst_n  input  1  observed DUT reset, active-low.
- mon_enable  input  1  observed count enable.
- mon_load  input  1  observed parallel load.
- mon_up_down_n  input  1  observed direction: 1 = up, 0 = down.
- mon_data_input  input  WIDTH  observed load value.
- mon_data_output  input  WIDTH  observed DUT counter value.
- chk_en  input  1  gates comparisons. The model keeps tracking while chk_en=0.
- synced  output  1  model is aligned with the DUT.
- mismatch  output  1  one-cycle pulse, registered.
- err_sticky  output  1  set on the first mismatch, cleared only by rst.
- chk_count  output  CHK_CNT_W  number of comparisons performed, saturating.
- err_count  output  ERR_CNT_W  number of mismatches, saturating.
- first_exp  output  WIDTH  expected value at the first mismatch.
- first_act  output  WIDTH  actual value at the first mismatch.

Behaviour:
- Reset (rst=1, asynchronous):
  - state = SYNC; exp_q = 0; vld_q = 0.
  - All outputs 0.
- Sampling: every input is sampled at the clk rising edge. The drivers change stimulus off-edge.
- Model update (next-state of exp_q), in priority order:
  - mon_rst_n=0 -> 0.
  - else mon_load=1 -> mon_data_input.
  - else mon_enable=1 and mon_up_down_n=1 -> exp_q+1, mod 2^WIDTH (15->0).
  - else mon_enable=1 and mon_up_down_n=0 -> exp_q-1, mod 2^WIDTH (0->15).
  - else hold.
  - load beats enable whenever both are sampled high.
- Latency:
  - Stimulus sampled at edge k is reflected in the DUT output after edge k.
  - That output is compared at edge k+1 against exp_q as updated at edge k.
  - vld_q <= (state==CHECK after edge k) & chk_en.
- State machine:
  - SYNC: exp_q is undefined-tracking and no compares occur.
    - Sampled mon_rst_n=0 -> exp_q<=0, go to CHECK.
    - Else sampled mon_load=1 -> exp_q<=mon_data_input, go to CHECK.
    - Otherwise stay in SYNC.
    - synced=0.
  - CHECK: model updates every cycle; synced=1.
    - At each edge with vld_q=1: chk_count++.
    - If mon_data_output != exp_q, then in the same edge: mismatch<=1, err_count++, err_sticky<=1.
    - On the first mismatch only, capture first_exp<=exp_q and first_act<=mon_data_output.
    - A mismatch with STOP_ON_ERROR=1 -> HALT.
  - HALT: no further compares; counters, captures and err_sticky are frozen; mismatch=0; synced stays 1. Exit only via rst.
- DUT reset during CHECK: the model is forced to 0 and compares continue. The DUT output must read 0 at the next compare.
- Counters saturate at all-ones and never wrap.
- mismatch is high for exactly one cycle per failing compare. It is high on consecutive cycles if consecutive compares fail.
- chk_en=0: vld_q is 0 from the next edge, and no count or error updates occur. The model still tracks the DUT, so re-enabling needs no resync.
- rst asserted at any point, including during HALT, returns the block to the reset state on the same assertion.

Test Plan:
- DUT reset, then load 4'h3, then 3 up-counts with a correct DUT:
  - synced=1 one edge after reset is sampled.
  - The DUT shows 3,4,5,6 and chk_count increments once per cycle.
  - err_count=0, mismatch never asserted.
- Wrap: load 4'hE, up x3, then down x3 -> expected sequence E,F,0,1,0,F,E with no errors.
- Simultaneous load=1, enable=1, up_down_n=1, data_input=4'h9 -> expected 4'h9, not exp+1. A DUT answering A gives mismatch=1, first_exp=9, first_act=A, err_count=1.
- STOP_ON_ERROR=1 with a fault injected at value 7 (DUT shows 8) followed by 3 further bad cycles:
  - err_count=1, err_sticky=1, state HALT.
  - chk_count frozen, mismatch pulse width 1.
- No DUT reset or load after rst, counting only -> synced=0, chk_count=0 throughout. A later load of 4'h5 brings synced=1 and compares start at the following edge.
- Mid-run: chk_en=0 for 4 counting cycles, then 1 -> no counts advance while disabled; on re-enable compares pass with no resync.
- mon_rst_n pulse while at 4'hB -> expected 0 at the next compare.
